// File: rtl/hs32_xmem_ctl.sv
// External SRAM controller: one 32-bit request becomes two 16-bit async SRAM cycles (low half, then high half).
// Latency stb->ack is 2*WAIT_STATES+4 cycles; stb is only sampled in IDLE, so the arbiter is held off while busy.
module hs32_xmem_ctl #(
   parameter int WAIT_STATES = 2,
   parameter int ADDR_W      = 18
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic [31:0]       i_addr,
   input  logic              i_rw,
   input  logic [31:0]       i_dtw,
   output logic [31:0]       o_dtr,
   input  logic              i_stb,
   output logic              o_ack,
   output logic              o_busy,
   output logic [ADDR_W-1:0] o_sram_a,
   output logic [15:0]       o_sram_dq_o,
   input  logic [15:0]       i_sram_dq_i,
   output logic              o_sram_dq_oe,
   output logic              o_sram_ce_n,
   output logic              o_sram_oe_n,
   output logic              o_sram_we_n
);

   localparam int CW = (WAIT_STATES < 2) ? 1 : $clog2(WAIT_STATES + 1);

   typedef enum logic [2:0] {S_IDLE, S_LO, S_TURN, S_HI, S_DONE} state_t;

   state_t            r_state, w_next;
   logic [CW-1:0]     r_cnt, w_cnt_nxt;
   logic [ADDR_W-2:0] r_addr;
   logic              r_rw;
   logic [31:0]       r_dtw;
   logic [31:0]       r_dtr;
   logic              w_phase, w_half, w_last, w_latch;
   logic              w_unused;

   assign w_unused = ^{i_addr[31:ADDR_W+1], i_addr[1:0]};

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_addr  <= '0;
         r_rw    <= 1'b0;
         r_dtw   <= '0;
         r_dtr   <= '0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_nxt;
         if (w_latch) begin
            r_addr <= i_addr[ADDR_W:2];
            r_rw   <= i_rw;
            r_dtw  <= i_dtw;
         end
         // read data is sampled at the end of the phase, after the full access time
         if (w_phase && !r_rw && w_last) begin
            if (w_half) r_dtr[31:16] <= i_sram_dq_i;
            else        r_dtr[15:0]  <= i_sram_dq_i;
         end
      end
   end

   always_comb begin
      w_next       = r_state;
      w_cnt_nxt    = r_cnt;
      w_latch      = 1'b0;
      w_half       = (r_state == S_HI);
      w_phase      = (r_state == S_LO) || (r_state == S_HI);
      w_last       = (r_cnt == '0);

      case (r_state)
         S_IDLE: begin
            if (i_stb) begin
               w_latch   = 1'b1;
               w_next    = S_LO;
               w_cnt_nxt = CW'(WAIT_STATES);
            end
         end
         S_LO: begin
            if (w_last) w_next = S_TURN;
            else        w_cnt_nxt = r_cnt - CW'(1);
         end
         S_TURN: begin
            w_next    = S_HI;
            w_cnt_nxt = CW'(WAIT_STATES);
         end
         S_HI: begin
            if (w_last) w_next = S_DONE;
            else        w_cnt_nxt = r_cnt - CW'(1);
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase

      o_ack        = (r_state == S_DONE);
      o_busy       = (r_state != S_IDLE);
      o_dtr        = r_dtr;
      o_sram_a     = {r_addr, w_half};
      o_sram_ce_n  = !w_phase;
      o_sram_oe_n  = !(w_phase && !r_rw);
      o_sram_dq_oe = w_phase && r_rw;
      // we_n releases one cycle early so address and data hold across its rising edge
      o_sram_we_n  = !(w_phase && r_rw && !w_last);
      o_sram_dq_o  = o_sram_dq_oe ? (w_half ? r_dtw[31:16] : r_dtw[15:0]) : 16'h0000;
   end

endmodule

// File: tb/tb_hs32_xmem_ctl.sv
// Bench for hs32_xmem_ctl: two instances (WAIT_STATES=2 and 1) with behavioural SRAMs,
// per-cycle pin model and a read-data scoreboard.
module tb_hs32_xmem_ctl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        do_preload;
   logic [31:0] t_addr [2];
   logic        t_rw   [2];
   logic [31:0] t_dtw  [2];
   logic [31:0] t_dtr  [2];
   logic        t_stb  [2];
   logic        t_ack  [2];
   logic        t_busy [2];
   logic [17:0] t_sa   [2];
   logic [15:0] t_dqo  [2];
   logic [15:0] t_dqi  [2];
   logic        t_dqoe [2];
   logic        t_ce   [2];
   logic        t_oe   [2];
   logic        t_we   [2];

   logic [15:0] mem [2][1024];
   logic [31:0] sb [$];
   int          n_chk  = 0;
   int          n_pass = 0;

   hs32_xmem_ctl #(.WAIT_STATES(2), .ADDR_W(18)) u_dut0 (
      .i_clk(clk), .i_reset(rst), .i_addr(t_addr[0]), .i_rw(t_rw[0]), .i_dtw(t_dtw[0]),
      .o_dtr(t_dtr[0]), .i_stb(t_stb[0]), .o_ack(t_ack[0]), .o_busy(t_busy[0]),
      .o_sram_a(t_sa[0]), .o_sram_dq_o(t_dqo[0]), .i_sram_dq_i(t_dqi[0]),
      .o_sram_dq_oe(t_dqoe[0]), .o_sram_ce_n(t_ce[0]), .o_sram_oe_n(t_oe[0]),
      .o_sram_we_n(t_we[0]));

   hs32_xmem_ctl #(.WAIT_STATES(1), .ADDR_W(18)) u_dut1 (
      .i_clk(clk), .i_reset(rst), .i_addr(t_addr[1]), .i_rw(t_rw[1]), .i_dtw(t_dtw[1]),
      .o_dtr(t_dtr[1]), .i_stb(t_stb[1]), .o_ack(t_ack[1]), .o_busy(t_busy[1]),
      .o_sram_a(t_sa[1]), .o_sram_dq_o(t_dqo[1]), .i_sram_dq_i(t_dqi[1]),
      .o_sram_dq_oe(t_dqoe[1]), .o_sram_ce_n(t_ce[1]), .o_sram_oe_n(t_oe[1]),
      .o_sram_we_n(t_we[1]));

   // behavioural async SRAMs (write modelled at the clock edge while we_n is low)
   always @(posedge clk) begin
      if (do_preload) begin
         mem[0][10'h082] <= 16'h5678;
         mem[0][10'h083] <= 16'h1234;
         mem[1][10'h010] <= 16'h9ABC;
         mem[1][10'h011] <= 16'h0F0F;
      end else begin
         for (int s = 0; s < 2; s++)
            if (!t_ce[s] && !t_we[s]) mem[s][t_sa[s][9:0]] <= t_dqo[s];
      end
   end
   assign t_dqi[0] = (!t_ce[0] && !t_oe[0]) ? mem[0][t_sa[0][9:0]] : 16'h0000;
   assign t_dqi[1] = (!t_ce[1] && !t_oe[1]) ? mem[1][t_sa[1][9:0]] : 16'h0000;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
   endtask

   task automatic check_reset(input int sel, input string tag);
      check({tag, "_ctl"}, {t_ack[sel], t_busy[sel], t_dqoe[sel], t_ce[sel], t_oe[sel], t_we[sel]},
            6'b000111);
      check({tag, "_dat"}, {t_dtr[sel], t_sa[sel], t_dqo[sel]}, 66'h0);
   endtask

   // one request; hold keeps stb high through DONE, abort_k asserts reset on that cycle
   task automatic run_req(input int sel, input logic rw, input logic [31:0] addr,
                          input logic [31:0] dtw, input logic [31:0] exp_dtr,
                          input bit hold, input int abort_k);
      int         w;
      int         lat;
      int         p;
      bit         lo, hi;
      logic [5:0] e;
      w   = (sel == 0) ? 2 : 1;
      lat = 2 * w + 4;
      @(negedge clk);
      check("idle", {t_busy[sel], t_ce[sel], t_ack[sel]}, 3'b010);
      t_addr[sel] = addr;
      t_rw[sel]   = rw;
      t_dtw[sel]  = dtw;
      t_stb[sel]  = 1'b1;
      sb.push_back(exp_dtr);
      for (int k = 1; k <= lat; k++) begin
         @(negedge clk);
         if (!hold) t_stb[sel] = 1'b0;
         lo = (k <= w + 1);
         hi = (k >= w + 3) && (k <= 2 * w + 3);
         p  = lo ? k - 1 : k - (w + 3);
         e  = {!(lo || hi), !((lo || hi) && !rw), !((lo || hi) && rw && p != w),
               (lo || hi) && rw, k == lat, 1'b1};
         check("strobes", {t_ce[sel], t_oe[sel], t_we[sel], t_dqoe[sel], t_ack[sel], t_busy[sel]}, e);
         if (lo || hi) check("sram_a", t_sa[sel], {addr[18:2], hi});
         if ((lo || hi) && rw) check("dq_o", t_dqo[sel], hi ? dtw[31:16] : dtw[15:0]);
         if (t_ack[sel]) begin
            if (sb.size() == 0) check("spurious_ack", 1, 0);
            else                check("dtr", t_dtr[sel], sb.pop_front());
         end
         if (k == abort_k) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check_reset(sel, "abort");
            sb.delete();
            return;
         end
      end
      check("ack_count", sb.size(), 0);
      sb.delete();
   endtask

   initial begin
      rst        = 1'b1;
      do_preload = 1'b1;
      for (int s = 0; s < 2; s++) begin
         t_addr[s] = '0; t_rw[s] = 1'b0; t_dtw[s] = '0; t_stb[s] = 1'b0;
      end
      repeat (3) @(negedge clk);
      check_reset(0, "reset0");
      check_reset(1, "reset1");
      rst        = 1'b0;
      do_preload = 1'b0;

      run_req(0, 1'b0, 32'h0000_0104, 32'h0,         32'h1234_5678, 1'b0, 0);
      run_req(0, 1'b1, 32'h0000_0104, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 0);
      run_req(0, 1'b0, 32'h0000_0104, 32'h0,         32'hDEAD_BEEF, 1'b0, 0);
      run_req(1, 1'b0, 32'h0000_0020, 32'h0,         32'h0F0F_9ABC, 1'b0, 0);
      // back-to-back with stb held through DONE
      run_req(0, 1'b1, 32'h0000_0200, 32'h1122_3344, 32'hDEAD_BEEF, 1'b1, 0);
      run_req(0, 1'b0, 32'h0000_0200, 32'h0,         32'h1122_3344, 1'b0, 0);
      // reset during the second HI cycle of a write
      run_req(0, 1'b1, 32'h0000_0300, 32'h5566_7788, 32'h0,         1'b0, 6);
      run_req(0, 1'b0, 32'h0000_0104, 32'h0,         32'hDEAD_BEEF, 1'b0, 0);
      // address aliasing on ignored high and low bits
      run_req(0, 1'b1, 32'hFFF8_0004, 32'hCAFE_F00D, 32'hDEAD_BEEF, 1'b0, 0);
      run_req(0, 1'b0, 32'hFFF8_0007, 32'h0,         32'hCAFE_F00D, 1'b0, 0);
      run_req(1, 1'b0, 32'h0000_0023, 32'h0,         32'h0F0F_9ABC, 1'b0, 0);

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
